// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// One cycle push-to-outValid; inReady is registered (~skid valid), flush squashes to a bubble.
module pipe_stage_skid_reg #(
  parameter int                 DATA_W     = 32,
  parameter int                 CTRL_W     = 8,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [CTRL_W-1:0] ctrlIn,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] dataOut,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic [1:0]        occupancy
);

  logic              main_v;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_v;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic push;
  logic pop;

  // Handshake outputs come straight from flops, so no in->out combinational path.
  assign inReady   = ~skid_v;
  assign outValid  = main_v;
  assign push      = inValid & inReady;
  assign pop       = outValid & outReady;
  assign dataOut   = main_data;
  assign ctrlOut   = main_ctrl & {CTRL_W{main_v}};
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v    <= 1'b0;
      main_ctrl <= '0;
      main_data <= RESET_DATA;
      skid_v    <= 1'b0;
      skid_ctrl <= '0;
      skid_data <= RESET_DATA;
    end else if (flush) begin
      // Squash wins over any handshake in the same cycle; payload registers hold.
      main_v    <= 1'b0;
      main_ctrl <= '0;
      skid_v    <= 1'b0;
      skid_ctrl <= '0;
    end else if (!main_v) begin
      if (push) begin
        main_v    <= 1'b1;
        main_ctrl <= ctrlIn;
        main_data <= dataIn;
      end
    end else if (!skid_v) begin
      if (push && pop) begin
        main_ctrl <= ctrlIn;
        main_data <= dataIn;
      end else if (push) begin
        skid_v    <= 1'b1;
        skid_ctrl <= ctrlIn;
        skid_data <= dataIn;
      end else if (pop) begin
        main_v <= 1'b0;
      end
    end else if (pop) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
      skid_v    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Drives a default instance and a 64/3/DEAD instance in lockstep against a FIFO scoreboard.
module tb_pipe_stage_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        inValid;
  logic        outReady;
  logic [63:0] din;
  logic [7:0]  cin;

  logic        inReady_a, outValid_a;
  logic [31:0] dataOut_a;
  logic [7:0]  ctrlOut_a;
  logic [1:0]  occ_a;

  logic        inReady_b, outValid_b;
  logic [63:0] dataOut_b;
  logic [2:0]  ctrlOut_b;
  logic [1:0]  occ_b;

  always #5 clk = ~clk;

  pipe_stage_skid_reg dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(inReady_a),
    .dataIn(din[31:0]), .ctrlIn(cin),
    .outValid(outValid_a), .outReady(outReady),
    .dataOut(dataOut_a), .ctrlOut(ctrlOut_a), .occupancy(occ_a)
  );

  pipe_stage_skid_reg #(.DATA_W(64), .CTRL_W(3), .RESET_DATA(64'hDEAD)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(inReady_b),
    .dataIn(din), .ctrlIn(cin[2:0]),
    .outValid(outValid_b), .outReady(outReady),
    .dataOut(dataOut_b), .ctrlOut(ctrlOut_b), .occupancy(occ_b)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } beat_t;

  beat_t       q[$];
  logic [63:0] hold_a;
  logic [63:0] hold_b;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    chk("occ_a", 64'(occ_a), 64'(n));
    chk("occ_b", 64'(occ_b), 64'(n));
    chk("rdy_a", 64'(inReady_a), 64'(n < 2));
    chk("rdy_b", 64'(inReady_b), 64'(n < 2));
    chk("vld_a", 64'(outValid_a), 64'(n > 0));
    chk("vld_b", 64'(outValid_b), 64'(n > 0));
    if (n > 0) begin
      hold_a = 64'(q[0].d[31:0]);
      hold_b = q[0].d;
      chk("ctl_a", 64'(ctrlOut_a), 64'(q[0].c));
      chk("ctl_b", 64'(ctrlOut_b), 64'(q[0].c[2:0]));
    end else begin
      chk("ctl_a", 64'(ctrlOut_a), 64'd0);
      chk("ctl_b", 64'(ctrlOut_b), 64'd0);
    end
    chk("dat_a", 64'(dataOut_a), hold_a);
    chk("dat_b", dataOut_b, hold_b);
  endtask

  // One cycle: drive, check at the falling edge, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [63:0] d, input logic [7:0] c,
                      input logic rdy, input logic fl);
    logic  do_push, do_pop;
    beat_t b;
    inValid  = v;
    din      = d;
    cin      = c;
    outReady = rdy;
    flush    = fl;
    @(negedge clk);
    check_outputs();
    do_push = v && (q.size() < 2);
    do_pop  = (q.size() > 0) && rdy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        b.d = d;
        b.c = c;
        q.push_back(b);
      end
    end
    #1;
  endtask

  // Reset asserted between clock edges must clear everything without a clock.
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    inValid = 1'b0;
    flush   = 1'b0;
    q.delete();
    hold_a = 64'd0;
    hold_b = 64'hDEAD;
    check_outputs();
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    din      = '0;
    cin      = '0;
    hold_a   = 64'd0;
    hold_b   = 64'hDEAD;
    async_reset();

    // Streaming at full rate
    step(1'b1, 64'h4, 8'h11, 1'b1, 1'b0);
    step(1'b1, 64'h8, 8'h22, 1'b1, 1'b0);
    step(1'b1, 64'hC, 8'h33, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    // Stall fills the skid; 0xC waits until inReady returns
    step(1'b1, 64'hA, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 64'hB, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 64'hC, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 64'hC, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 64'hC, 8'hC3, 1'b1, 1'b0);
    step(1'b1, 64'hC, 8'hC3, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    // Flush with a full stage and a concurrent push/pop
    step(1'b1, 64'h1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 64'h2, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 64'hD, 8'hFF, 1'b1, 1'b1);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 64'hE, 8'h01, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    // Flush into an empty stage with a push
    step(1'b1, 64'h9, 8'h07, 1'b1, 1'b1);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    // Bubble gating: control drops, payload stays
    step(1'b1, 64'h77, 8'h0F, 1'b0, 1'b0);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           {$urandom, $urandom},
           8'($urandom),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0));
    end

    // Reset mid-stream, then the first push lands in main
    step(1'b1, 64'h31, 8'h12, 1'b0, 1'b0);
    step(1'b1, 64'h32, 8'h34, 1'b0, 1'b0);
    async_reset();
    step(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 64'h5, 8'h56, 1'b0, 1'b0);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
